shift_register_univ: RTL and testbench

- Parametrised universal shift register. Successor to the fixed 4-bit serial-in/parallel-out DFF chain.
- Adds the following over a plain serial chain:
  - configurable width;
  - bidirectional shift and rotate;
  - parallel load and clear;
  - a burst engine that performs N back-to-back shifts from a single start pulse, with busy/done status.
- Used as the general shift/serialisation element in the lab datapaths.

---
 rtl/shift_register_univ.sv | 148 ++++++++++++++
 tb/tb_shift_register_univ.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/shift_register_univ.sv
// shift_register_univ
//   Parametrised universal shift register with single-cycle ops (shift,
//   rotate, load, clear) and a burst engine that runs burst_len back-to-back
//   shifts from one start pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   en         enables the single-cycle op in IDLE
//   op[2:0]    single-cycle op: 0 HOLD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 LOAD,
//              6 CLR, 7 reserved (HOLD)
//   ser_in     serial input for SHL/SHR
//   pdata      parallel load data
//   start      burst request pulse (IDLE only, beats en/op)
//   burst_op   burst shift type: 0 SHL, 1 SHR, 2 ROL, 3 ROR
//   burst_len  number of shifts in a burst (0 goes straight to DONE)
//   q          register contents
//   ser_out    bit shifted out by the last SHL/SHR; 0 after rotate/load/clear
//   busy       high while the burst engine is shifting
//   done       one-cycle pulse when a burst completes
module shift_register_univ #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [1:0]       burst_op,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_LOAD = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       bop, bop_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             so_nxt;
    logic [2:0]       eff_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bop     <= 2'd0;
            q       <= '0;
            ser_out <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bop     <= bop_nxt;
            q       <= q_nxt;
            ser_out <= so_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bop_nxt   = bop;
        eff_op    = OP_HOLD;

        case (state)
            S_IDLE: begin
                if (start) begin
                    // No shift in the start cycle; only capture the request.
                    bop_nxt   = burst_op;
                    cnt_nxt   = burst_len;
                    state_nxt = (burst_len == '0) ? S_DONE : S_BUSY;
                end else if (en) begin
                    eff_op = op;
                end
            end
            S_BUSY: begin
                // Burst encodings 0..3 line up with single ops 1..4.
                eff_op  = {1'b0, bop} + 3'd1;
                cnt_nxt = cnt - 1'b1;
                if (cnt == CNT_W'(1))
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Shared datapath for single ops and burst shifts.
    always_comb begin
        q_nxt  = q;
        so_nxt = ser_out;
        case (eff_op)
            OP_SHL: begin
                q_nxt  = {q[WIDTH-2:0], ser_in};
                so_nxt = q[WIDTH-1];
            end
            OP_SHR: begin
                q_nxt  = {ser_in, q[WIDTH-1:1]};
                so_nxt = q[0];
            end
            OP_ROL: begin
                q_nxt  = {q[WIDTH-2:0], q[WIDTH-1]};
                so_nxt = 1'b0;
            end
            OP_ROR: begin
                q_nxt  = {q[0], q[WIDTH-1:1]};
                so_nxt = 1'b0;
            end
            OP_LOAD: begin
                q_nxt  = pdata;
                so_nxt = 1'b0;
            end
            OP_CLR: begin
                q_nxt  = '0;
                so_nxt = 1'b0;
            end
            default: begin
                // HOLD and reserved encoding
            end
        endcase
    end

    assign busy = (state == S_BUSY);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_shift_register_univ.sv
module tb_shift_register_univ;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [2:0]       op;
    logic             ser_in;
    logic [WIDTH-1:0] pdata;
    logic             start;
    logic [1:0]       burst_op;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;

    int passed = 0;
    int total  = 0;

    shift_register_univ #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .op        (op),
        .ser_in    (ser_in),
        .pdata     (pdata),
        .start     (start),
        .burst_op  (burst_op),
        .burst_len (burst_len),
        .q         (q),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Single op in IDLE, one edge.
    task automatic do_op(input logic [2:0] o, input logic si, input logic [7:0] pd);
        en = 1'b1; op = o; ser_in = si; pdata = pd;
        tick();
        en = 1'b0; op = 3'd0;
    endtask

    initial begin
        int bc, dc;
        reset = 1'b1; en = 1'b0; op = 3'd0; ser_in = 1'b0; pdata = '0;
        start = 1'b0; burst_op = 2'd0; burst_len = '0;

        // Reset
        tick(); tick();
        check("rst_q", q, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_so", ser_out, 0);
        reset = 1'b0;

        // Single ops
        do_op(3'd5, 1'b0, 8'hA5); check("load_q", q, 8'hA5);
        do_op(3'd1, 1'b1, 8'h00); check("shl_q", q, 8'h4B); check("shl_so", ser_out, 1);
        do_op(3'd2, 1'b0, 8'h00); check("shr_q", q, 8'h25); check("shr_so", ser_out, 1);
        do_op(3'd3, 1'b0, 8'h00); check("rol_q", q, 8'h4A); check("rol_so", ser_out, 0);
        do_op(3'd4, 1'b0, 8'h00); check("ror_q", q, 8'h25);
        do_op(3'd6, 1'b0, 8'h00); check("clr_q", q, 8'h00);
        do_op(3'd5, 1'b0, 8'hBC);
        do_op(3'd1, 1'b0, 8'h00); check("shl2_q", q, 8'h78); check("shl2_so", ser_out, 1);
        en = 1'b0; op = 3'd1; ser_in = 1'b1; tick();
        check("en0_q", q, 8'h78); check("en0_so", ser_out, 1);
        do_op(3'd7, 1'b1, 8'hFF); check("rsvd_q", q, 8'h78); check("rsvd_so", ser_out, 1);

        // Burst rotate, with start/LOAD held during BUSY and DONE
        do_op(3'd5, 1'b0, 8'h81);
        start = 1'b1; burst_op = 2'd2; burst_len = 4'd3;
        tick();
        check("br_b0_busy", busy, 1); check("br_b0_q", q, 8'h81);
        en = 1'b1; op = 3'd5; pdata = 8'hFF; burst_op = 2'd0; burst_len = 4'd7;
        tick(); check("br_b1_busy", busy, 1); check("br_b1_q", q, 8'h03);
        tick(); check("br_b2_busy", busy, 1); check("br_b2_q", q, 8'h06);
        tick(); check("br_d_busy", busy, 0); check("br_d_done", done, 1); check("br_d_q", q, 8'h0C);
        start = 1'b0; en = 1'b0; op = 3'd0;
        tick(); check("br_i_done", done, 0); check("br_i_busy", busy, 0); check("br_i_q", q, 8'h0C);

        // Zero-length burst
        start = 1'b1; burst_op = 2'd0; burst_len = 4'd0;
        tick(); check("z_busy", busy, 0); check("z_done", done, 1); check("z_q", q, 8'h0C);
        start = 1'b0;
        tick(); check("z_done2", done, 0); check("z_q2", q, 8'h0C);

        // Max-length SHR burst filling with ones
        do_op(3'd6, 1'b0, 8'h00);
        start = 1'b1; burst_op = 2'd1; burst_len = 4'd15; ser_in = 1'b1;
        tick(); start = 1'b0;
        bc = 0; dc = 0;
        if (busy) bc++;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy) bc++;
            if (done) dc++;
        end
        check("max_busy_cycles", bc, 15);
        check("max_done_cnt", dc, 1);
        check("max_q", q, 8'hFF);
        check("max_so", ser_out, 1);

        // Reset in the 4th busy cycle of a ROR burst
        do_op(3'd5, 1'b0, 8'h81);
        start = 1'b1; burst_op = 2'd3; burst_len = 4'd10;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        check("mr_b4_busy", busy, 1); check("mr_b4_q", q, 8'h30); check("mr_b4_so", ser_out, 0);
        reset = 1'b1;
        tick(); check("mr_rst_q", q, 8'h00); check("mr_rst_busy", busy, 0); check("mr_rst_done", done, 0);
        reset = 1'b0;
        tick(); check("mr_post_done", done, 0); check("mr_post_busy", busy, 0);

        // New burst after reset
        do_op(3'd5, 1'b0, 8'h01);
        start = 1'b1; burst_op = 2'd2; burst_len = 4'd2;
        tick(); start = 1'b0; check("nb_busy", busy, 1);
        tick(); check("nb_q1", q, 8'h02);
        tick(); check("nb_q2", q, 8'h04); check("nb_done", done, 1);
        tick(); check("nb_idle", done, 0);

        // start beats en/op LOAD in IDLE
        start = 1'b1; en = 1'b1; op = 3'd5; pdata = 8'hAA;
        burst_op = 2'd0; burst_len = 4'd1; ser_in = 1'b1;
        tick(); check("pri_busy", busy, 1); check("pri_q", q, 8'h04);
        start = 1'b0; en = 1'b0; op = 3'd0;
        tick(); check("pri_q2", q, 8'h09); check("pri_done", done, 1); check("pri_so", ser_out, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
